// File: rtl/jtcop_ba0_arb.sv
// SDRAM bank 0 arbiter: five requesters (CPU RAM, ROM, B0, B1, B2) share one
// SDRAM port. Fixed priority with starvation promotion; single-word accesses.

// Per-slot starvation counter: counts lost arbitrations while pending.
module jtcop_ba0_starve #(
    parameter int STARVE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic arb,
    input  logic pending,
    input  logic won,
    output logic starved
);
    localparam logic [2:0] LIMIT = 3'(STARVE);

    logic [2:0] cnt;

    // Clear on win or when idle, otherwise saturate-count losses
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!cs || (arb && won))
            cnt <= '0;
        else if (arb && pending && cnt != LIMIT)
            cnt <= cnt + 3'd1;
    end

    assign starved = (cnt == LIMIT);
endmodule

module jtcop_ba0_arb #(
    parameter int AW     = 22,
    parameter int STARVE = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [4:0]     slot_cs,
    input  logic [5*AW-1:0] slot_addr,
    input  logic           slot0_wen,
    input  logic [15:0]    slot0_din,
    input  logic [1:0]     slot0_wrmask,
    output logic [4:0]     slot_ok,
    output logic [15:0]    slot_dout,
    output logic [AW-1:0]  sdram_addr,
    output logic           sdram_rd,
    output logic           sdram_wr,
    input  logic           sdram_ack,
    input  logic           data_dst,
    input  logic           data_rdy,
    input  logic [15:0]    data_read,
    output logic [15:0]    data_write,
    output logic [1:0]     sdram_wrmask
);
    typedef enum logic [1:0] { IDLE, REQ, WAIT, DONE } state_t;

    state_t              st;
    logic [4:0][AW-1:0]  addr_a;
    logic [4:0][AW-1:0]  prev_a;
    logic [4:0]          same, ok_keep, pending, starved, cand;
    logic [2:0]          sel, win;
    logic                arb, is_wr;
    logic                unused;

    // Burst start carries no information for single-word transfers
    assign unused = data_dst;

    assign addr_a = slot_addr;

    // An ok bit survives only while cs is held and the address is unchanged;
    // a changed address counts as not-ok right away so it can re-arbitrate
    always_comb begin
        for (int i = 0; i < 5; i++) same[i] = (addr_a[i] == prev_a[i]);
        ok_keep = slot_ok & slot_cs & same;
        pending = slot_cs & ~ok_keep;
        arb     = (st == IDLE) && (|pending);
    end

    // Starved pending slots take precedence; lowest index wins within a group
    always_comb begin
        cand = (|(pending & starved)) ? (pending & starved) : pending;
        sel  = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (cand[i]) sel = 3'(i);
    end

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_starve
            jtcop_ba0_starve #(.STARVE(STARVE)) u_starve (
                .clk     (clk),
                .rst     (rst),
                .cs      (slot_cs[g]),
                .arb     (arb),
                .pending (pending[g]),
                .won     (sel == 3'(g)),
                .starved (starved[g])
            );
        end
    endgenerate

    // Request/response sequencer with registered SDRAM-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= IDLE;
            sdram_rd     <= 1'b0;
            sdram_wr     <= 1'b0;
            slot_ok      <= '0;
            slot_dout    <= '0;
            sdram_addr   <= '0;
            data_write   <= '0;
            sdram_wrmask <= 2'b11;
            win          <= '0;
            is_wr        <= 1'b0;
            prev_a       <= '0;
        end else begin
            prev_a  <= addr_a;
            slot_ok <= ok_keep;
            case (st)
                IDLE: if (|pending) begin
                    win        <= sel;
                    sdram_addr <= addr_a[sel];
                    if (sel == 3'd0 && slot0_wen) begin
                        is_wr        <= 1'b1;
                        sdram_wr     <= 1'b1;
                        data_write   <= slot0_din;
                        sdram_wrmask <= slot0_wrmask;
                    end else begin
                        is_wr    <= 1'b0;
                        sdram_rd <= 1'b1;
                    end
                    st <= REQ;
                end
                REQ: if (sdram_ack) begin
                    sdram_rd <= 1'b0;
                    sdram_wr <= 1'b0;
                    st       <= WAIT;
                end
                WAIT: if (data_rdy) begin
                    if (!is_wr) slot_dout <= data_read;
                    st <= DONE;
                end
                DONE: begin
                    // Result is only delivered if the requester still wants it
                    if (slot_cs[win] && addr_a[win] == sdram_addr)
                        slot_ok <= ok_keep | (5'd1 << win);
                    st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtcop_ba0_arb.sv
// Directed bench for jtcop_ba0_arb with a one-cycle-response SDRAM model.
module tb_jtcop_ba0_arb;
    localparam int AW = 22;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [4:0]           slot_cs = '0;
    logic [4:0][AW-1:0]   saddr = '0;
    logic                 slot0_wen = 1'b0;
    logic [15:0]          slot0_din = '0;
    logic [1:0]           slot0_wrmask = '0;
    logic [4:0]           slot_ok;
    logic [15:0]          slot_dout;
    logic [AW-1:0]        sdram_addr;
    logic                 sdram_rd, sdram_wr;
    logic                 sdram_ack = 1'b0;
    logic                 data_dst = 1'b0;
    logic                 data_rdy = 1'b0;
    logic [15:0]          data_read = '0;
    logic [15:0]          data_write;
    logic [1:0]           sdram_wrmask;

    int                   n_cmp = 0, n_err = 0;
    int                   rd_rise = 0, wr_rise = 0;
    logic [AW-1:0]        grants[$];
    logic [15:0]          rdata = '0;
    logic [15:0]          wr_data = '0;
    logic [1:0]           wr_mask = '0;
    logic                 no_rdy = 1'b0;

    jtcop_ba0_arb #(.AW(AW), .STARVE(4)) dut (
        .clk(clk), .rst(rst), .slot_cs(slot_cs), .slot_addr(saddr),
        .slot0_wen(slot0_wen), .slot0_din(slot0_din), .slot0_wrmask(slot0_wrmask),
        .slot_ok(slot_ok), .slot_dout(slot_dout), .sdram_addr(sdram_addr),
        .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_ack(sdram_ack),
        .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read),
        .data_write(data_write), .sdram_wrmask(sdram_wrmask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; SDRAM acks the cycle after it sees a request, then returns rdy
    task automatic tick();
        logic s_req, s_ack;
        @(negedge clk);
        s_req = sdram_rd | sdram_wr;
        s_ack = sdram_ack;
        @(posedge clk);
        #1;
        if (!no_rdy && s_ack) begin
            data_rdy  = 1'b1;
            data_read = rdata;
        end else
            data_rdy = 1'b0;
        sdram_ack = s_req && !s_ack;
        if ((sdram_rd | sdram_wr) && !s_req) begin
            grants.push_back(sdram_addr);
            if (sdram_rd) rd_rise++;
            if (sdram_wr) wr_rise++;
        end
        if (sdram_wr) begin
            wr_data = data_write;
            wr_mask = sdram_wrmask;
        end
    endtask

    task automatic wait_ok(input int idx, input string tag, output int n);
        n = 0;
        while (!slot_ok[idx] && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(slot_ok[idx]), 32'd1);
    endtask

    task automatic clr_log();
        grants.delete();
        rd_rise = 0;
        wr_rise = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, k;
        // Reset values
        @(posedge clk); @(posedge clk); #1;
        chk("rst_rd",     32'(sdram_rd), 32'd0);
        chk("rst_wr",     32'(sdram_wr), 32'd0);
        chk("rst_ok",     32'(slot_ok), 32'd0);
        chk("rst_dout",   32'(slot_dout), 32'd0);
        chk("rst_addr",   32'(sdram_addr), 32'd0);
        chk("rst_wdata",  32'(data_write), 32'd0);
        chk("rst_wmask",  32'(sdram_wrmask), 32'd3);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Single read on slot 2, five-cycle latency
        clr_log();
        rdata    = 16'hBEEF;
        saddr[2] = 22'h102010;
        slot_cs  = 5'b00100;
        wait_ok(2, "rd_ok", n);
        chk("rd_lat",   32'(n), 32'd5);
        chk("rd_okvec", 32'(slot_ok), 32'h04);
        chk("rd_dout",  32'(slot_dout), 32'hBEEF);
        chk("rd_rise",  32'(rd_rise), 32'd1);
        chk("rd_nowr",  32'(wr_rise), 32'd0);
        chk("rd_addr",  32'(grants[0]), 32'h102010);
        tick(); tick();
        chk("rd_hold",  32'(slot_ok), 32'h04);
        slot_cs = 5'b00000;
        tick();
        chk("rd_drop",  32'(slot_ok), 32'h00);
        chk("rd_idle",  32'(sdram_rd), 32'd0);

        // Write on slot 0; wen toggled mid-flight must not matter
        clr_log();
        rdata        = 16'hFFFF;
        saddr[0]     = 22'h000123;
        slot0_wen    = 1'b1;
        slot0_din    = 16'h1234;
        slot0_wrmask = 2'b01;
        slot_cs      = 5'b00001;
        tick(); tick();
        slot0_wen = 1'b0;
        wait_ok(0, "wr_ok", n);
        chk("wr_rise",  32'(wr_rise), 32'd1);
        chk("wr_nord",  32'(rd_rise), 32'd0);
        chk("wr_data",  32'(wr_data), 32'h1234);
        chk("wr_mask",  32'(wr_mask), 32'd1);
        chk("wr_dout",  32'(slot_dout), 32'hBEEF);
        chk("wr_okvec", 32'(slot_ok), 32'h01);
        slot_cs = 5'b00000;
        tick();

        // Priority: slot 0 before slot 4
        clr_log();
        rdata    = 16'h4444;
        saddr[0] = 22'h000200;
        saddr[4] = 22'h300400;
        slot_cs  = 5'b10001;
        wait_ok(4, "pri_ok4", n);
        chk("pri_n",    32'(grants.size()), 32'd2);
        chk("pri_1st",  32'(grants[0]), 32'h000200);
        chk("pri_2nd",  32'(grants[1]), 32'h300400);
        chk("pri_ok",   32'(slot_ok), 32'h11);
        slot_cs = 5'b00000;
        tick();

        // Starvation: slot 0 keeps re-requesting, slot 3 promoted on 5th arbitration
        clr_log();
        rdata    = 16'h3333;
        saddr[3] = 22'h003333;
        saddr[0] = 22'h000010;
        slot_cs  = 5'b01001;
        k = 0;
        n = 0;
        while (!slot_ok[3] && n < 200) begin
            tick();
            n++;
            if (slot_ok[0]) begin
                k++;
                saddr[0] = 22'(32'h10 + k);
            end
        end
        chk("stv_ok3",  32'(slot_ok[3]), 32'd1);
        chk("stv_n",    32'(grants.size()), 32'd5);
        chk("stv_g0",   32'(grants[0]), 32'h10);
        chk("stv_g3",   32'(grants[3]), 32'h13);
        chk("stv_win",  32'(grants[4]), 32'h003333);
        slot_cs = 5'b00000;
        tick(); tick();

        // Address change on slot 1 re-issues the read
        rdata    = 16'h1111;
        saddr[1] = 22'h011111;
        slot_cs  = 5'b00010;
        wait_ok(1, "ac_ok1", n);
        clr_log();
        rdata    = 16'h2222;
        saddr[1] = 22'h022222;
        tick();
        chk("ac_drop",  32'(slot_ok[1]), 32'd0);
        wait_ok(1, "ac_ok2", n);
        chk("ac_rise",  32'(rd_rise), 32'd1);
        chk("ac_addr",  32'(grants[0]), 32'h022222);
        chk("ac_dout",  32'(slot_dout), 32'h2222);
        slot_cs = 5'b00000;
        tick();

        // Reset while waiting for rdy
        no_rdy   = 1'b1;
        saddr[0] = 22'h0AAAAA;
        slot_cs  = 5'b00001;
        slot0_wen = 1'b0;
        tick(); tick(); tick();
        chk("rw_wait",  32'(sdram_rd), 32'd0);
        rst = 1'b1;
        #1;
        chk("rw_rd",    32'(sdram_rd), 32'd0);
        chk("rw_ok",    32'(slot_ok), 32'd0);
        chk("rw_dout",  32'(slot_dout), 32'd0);
        chk("rw_addr",  32'(sdram_addr), 32'd0);
        chk("rw_wdata", 32'(data_write), 32'd0);
        chk("rw_wmask", 32'(sdram_wrmask), 32'd3);
        slot_cs = 5'b00000;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        data_rdy  = 1'b1;
        sdram_ack = 1'b1;
        data_read = 16'hDEAD;
        @(posedge clk); #1;
        data_rdy  = 1'b0;
        sdram_ack = 1'b0;
        @(posedge clk); #1;
        chk("late_dout", 32'(slot_dout), 32'd0);
        chk("late_rd",   32'(sdram_rd), 32'd0);
        chk("late_ok",   32'(slot_ok), 32'd0);
        no_rdy   = 1'b0;
        rdata    = 16'h5A5A;
        saddr[2] = 22'h020202;
        slot_cs  = 5'b00100;
        wait_ok(2, "post_ok", n);
        chk("post_lat",  32'(n), 32'd5);
        chk("post_dout", 32'(slot_dout), 32'h5A5A);
        slot_cs = 5'b00000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
